uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader_pkg.sv | 17 +
 rtl/uart_boot_loader_word_assembler.sv | 28 ++
 rtl/uart_boot_loader.sv | 144 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared state encoding and protocol constants for the UART boot loader.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_START,
    LEN,
    DATA,
    CSUM,
    ACK,
    RUN
  } state_e;

  localparam logic [7:0] ACK_OK             = 8'hAA;
  localparam logic [7:0] ACK_BAD            = 8'h55;
  localparam logic [7:0] DEFAULT_START_BYTE = 8'h99;

endpackage

// File: rtl/uart_boot_loader_word_assembler.sv
// Little-endian byte-to-word shifter with a 2-bit byte counter; o_word is the
// complete word in the cycle the 4th byte is pushed (o_last=1).
module loader_word_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic [31:0] o_word
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_push) begin
      r_shift <= {i_byte, r_shift[23:8]};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_last = (r_cnt == 2'd3);
  assign o_word = {i_byte, r_shift};

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: pulls a framed image from the rx FIFO into instruction memory,
// acks, then hands the UART to the CPU. Define LOADER_CHECKSUM_EN for the checksum phase.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter logic [7:0]  START_BYTE = DEFAULT_START_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        uart_rx_data,
  input  logic              empty,
  output logic              uart_rd_en,
  output logic [7:0]        uart_tx_data,
  input  logic              full,
  output logic              uart_wr_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              boot_done,
  output logic [7:0]        cpu_rx_data,
  output logic              cpu_empty,
  input  logic              cpu_rd_en,
  input  logic [7:0]        cpu_tx_data,
  output logic              cpu_full,
  input  logic              cpu_wr_en
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = CSUM;
  logic [7:0] r_sum;
`else
  localparam state_e ST_AFTER_DATA = ACK;
`endif

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_words_left;
  logic [31:0]       r_imem_wdata;
  logic              r_imem_we;
  logic              r_boot_done;
  logic [7:0]        r_ack;

  logic        w_run;
  logic        w_loading;
  logic        w_pop;
  logic        w_asm_push;
  logic        w_last;
  logic [31:0] w_word;

  // rst gates the combinational strobes so nothing moves during the reset cycle.
  assign w_run      = (r_state == RUN) && !rst;
  assign w_loading  = !rst && (r_state inside {WAIT_START, LEN, DATA, CSUM});
  assign w_pop      = w_loading && !empty;
  assign w_asm_push = w_pop && (r_state inside {LEN, DATA});

  loader_word_assembler u_asm (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_push (w_asm_push),
    .i_byte (uart_rx_data),
    .o_last (w_last),
    .o_word (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_START;
      r_addr       <= '0;
      r_words_left <= '0;
      r_imem_we    <= 1'b0;
      r_imem_wdata <= '0;
      r_boot_done  <= 1'b0;
      r_ack        <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      if (r_imem_we) r_addr <= r_addr + ADDR_W'(1);
      unique case (r_state)
        WAIT_START: begin
          if (w_pop && (uart_rx_data == START_BYTE)) r_state <= LEN;
        end
        LEN: begin
          if (w_pop && w_last) begin
            r_words_left <= w_word;
            if (w_word != 32'd0) begin
              r_state <= DATA;
            end else begin
              r_state <= ST_AFTER_DATA;
              r_ack   <= ACK_OK;
            end
          end
        end
        DATA: begin
          if (w_pop) begin
`ifdef LOADER_CHECKSUM_EN
            r_sum <= r_sum + uart_rx_data;
`endif
            if (w_last) begin
              r_imem_we    <= 1'b1;
              r_imem_wdata <= w_word;
              r_words_left <= r_words_left - 32'd1;
              if (r_words_left == 32'd1) begin
                r_state <= ST_AFTER_DATA;
                r_ack   <= ACK_OK;
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (w_pop) begin
            r_ack   <= (uart_rx_data == r_sum) ? ACK_OK : ACK_BAD;
            r_state <= ACK;
          end
        end
`endif
        ACK: begin
          if (!full) begin
            r_state     <= RUN;
            r_boot_done <= 1'b1;
          end
        end
        RUN: r_state <= RUN;
        default: r_state <= WAIT_START;
      endcase
    end
  end

  assign uart_rd_en   = w_run ? cpu_rd_en : w_pop;
  assign uart_wr_en   = w_run ? cpu_wr_en : (!rst && (r_state == ACK) && !full);
  assign uart_tx_data = w_run ? cpu_tx_data : r_ack;
  assign cpu_rx_data  = w_run ? uart_rx_data : 8'h00;
  assign cpu_empty    = w_run ? empty : 1'b1;
  assign cpu_full     = w_run ? full : 1'b1;

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_imem_wdata;
  assign boot_done  = r_boot_done;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: FIFO model on both UART sides, table vectors,
// hand-written corner cases and randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_boot_loader;

  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    uart_rx_data;
  logic          empty;
  logic          uart_rd_en;
  logic [7:0]    uart_tx_data;
  logic          full;
  logic          uart_wr_en;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          boot_done;
  logic [7:0]    cpu_rx_data;
  logic          cpu_empty;
  logic          cpu_rd_en;
  logic [7:0]    cpu_tx_data;
  logic          cpu_full;
  logic          cpu_wr_en;

  uart_boot_loader #(.ADDR_W(AW), .START_BYTE(8'h99)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx_data (uart_rx_data),
    .empty        (empty),
    .uart_rd_en   (uart_rd_en),
    .uart_tx_data (uart_tx_data),
    .full         (full),
    .uart_wr_en   (uart_wr_en),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .boot_done    (boot_done),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_empty    (cpu_empty),
    .cpu_rd_en    (cpu_rd_en),
    .cpu_tx_data  (cpu_tx_data),
    .cpu_full     (cpu_full),
    .cpu_wr_en    (cpu_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bytes_in;  // [31:24] is sent first
    logic [31:0] exp;
  } vec_t;

  vec_t          vecs[4];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    rx_q[$];
  logic          stall_en = 1'b0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [7:0]    tx_q[$];
  int            we_run_err = 0;
  int            wr_full_err = 0;
  logic [7:0]    stim[$];
  logic [31:0]   exp_words[$];
  logic [7:0]    exp_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // rx FIFO model plus output monitor; samples at negedge+3, updates inputs at posedge+1.
  initial begin
    logic pop;
    logic prev_we;
    prev_we = 1'b0;
    empty = 1'b1;
    uart_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      #3;
      if (imem_we) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wdata);
        if (prev_we) we_run_err++;
      end
      prev_we = imem_we;
      if (uart_wr_en && full) wr_full_err++;
      if (uart_wr_en && !full) tx_q.push_back(uart_tx_data);
      pop = uart_rd_en && !empty;
      @(posedge clk);
      #1;
      if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
      empty = (rx_q.size() == 0) || (stall_en && ($urandom_range(0, 1) == 0));
      uart_rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_capture();
    wa_q.delete();
    wd_q.delete();
    tx_q.delete();
    we_run_err = 0;
    wr_full_err = 0;
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    cpu_tx_data = 8'h00;
    full = 1'b0;
    stall_en = 1'b0;
    rx_q.delete();
    tick(2);
    if (check) begin
      chk("rst uart_rd_en", {31'd0, uart_rd_en}, 32'd0);
      chk("rst uart_wr_en", {31'd0, uart_wr_en}, 32'd0);
      chk("rst imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst boot_done", {31'd0, boot_done}, 32'd0);
      chk("rst imem_wdata", imem_wdata, 32'd0);
      chk("rst uart_tx_data", {24'd0, uart_tx_data}, 32'd0);
      chk("rst imem_addr", {18'd0, imem_addr}, 32'd0);
      chk("rst cpu_empty", {31'd0, cpu_empty}, 32'd1);
      chk("rst cpu_full", {31'd0, cpu_full}, 32'd1);
    end
    rst = 1'b0;
    clear_capture();
    tick(1);
  endtask

  task automatic push_le(input logic [31:0] w);
    stim.push_back(w[7:0]);
    stim.push_back(w[15:8]);
    stim.push_back(w[23:16]);
    stim.push_back(w[31:24]);
  endtask

  task automatic send_stim();
    foreach (stim[i]) rx_q.push_back(stim[i]);
  endtask

  task automatic wait_boot(input string name);
    int c;
    int limit;
    c = 0;
    limit = 40 * stim.size() + 100;
    while (!boot_done && c < limit) begin
      tick(1);
      c++;
    end
    chk({name, " boot_done"}, {31'd0, boot_done}, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (rx_q.size() != 0 && c < 2000) begin
      tick(1);
      c++;
    end
    chk({name, " rx drained"}, rx_q.size(), 32'd0);
    tick(3);
  endtask

  // Frame-level reference: parse stim as the loader protocol defines it.
  function automatic void model();
    int         i;
    int         n;
    logic [7:0] sum;
    i = 0;
    sum = 8'h00;
    exp_words.delete();
    while (stim[i] != 8'h99) i++;
    i++;
    n = int'({stim[i+3], stim[i+2], stim[i+1], stim[i]});
    i += 4;
    for (int w = 0; w < n; w++) begin
      exp_words.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
      sum = sum + stim[i] + stim[i+1] + stim[i+2] + stim[i+3];
      i += 4;
    end
`ifdef LOADER_CHECKSUM_EN
    exp_ack = (stim[i] == sum) ? 8'hAA : 8'h55;
`else
    exp_ack = (sum == sum) ? 8'hAA : 8'hAA;
`endif
  endfunction

  task automatic compare_load(input string name);
    chk({name, " nwrites"}, wd_q.size(), exp_words.size());
    foreach (exp_words[k]) begin
      if (k < wd_q.size()) begin
        chk({name, " addr"}, {18'd0, wa_q[k]}, k);
        chk({name, " data"}, wd_q[k], exp_words[k]);
      end
    end
    chk({name, " ntx"}, tx_q.size(), 32'd1);
    if (tx_q.size() != 0) chk({name, " ack"}, {24'd0, tx_q[0]}, {24'd0, exp_ack});
    chk({name, " we width"}, we_run_err, 32'd0);
    chk({name, " wr while full"}, wr_full_err, 32'd0);
  endtask

  task automatic build_random(input int n, input bit good_csum, input int garbage);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'h00;
    stim.delete();
    repeat (garbage) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h99) b = 8'h98;
      stim.push_back(b);
    end
    stim.push_back(8'h99);
    push_le(32'(n));
    repeat (4 * n) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back(b);
      sum = sum + b;
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(good_csum ? sum : sum + 8'd1);
`else
    if (good_csum) sum = 8'h00;
`endif
  endtask

  task automatic run_table(input bit stall, input string name);
    logic [7:0] sum;
    sum = 8'h00;
    stim.delete();
    stim.push_back(8'h12);
    stim.push_back(8'h99);
    push_le(32'd4);
    for (int i = 0; i < 4; i++) begin
      for (int j = 3; j >= 0; j--) begin
        stim.push_back(vecs[i].bytes_in[j*8 +: 8]);
        sum = sum + vecs[i].bytes_in[j*8 +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(sum);
`endif
    stall_en = stall;
    send_stim();
    wait_boot(name);
    stall_en = 1'b0;
    tick(2);
    chk({name, " nwrites"}, wd_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wd_q.size()) begin
        chk({name, " addr"}, {18'd0, wa_q[i]}, i);
        chk({name, " word"}, wd_q[i], vecs[i].exp);
      end
    end
    chk({name, " ntx"}, tx_q.size(), 32'd1);
    if (tx_q.size() != 0) chk({name, " ack"}, {24'd0, tx_q[0]}, 32'hAA);
    chk({name, " we width"}, we_run_err, 32'd0);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{bytes_in: 32'hEFBEADDE, exp: 32'hDEADBEEF};
    vecs[1] = '{bytes_in: 32'h78563412, exp: 32'h12345678};
    vecs[2] = '{bytes_in: 32'h00000000, exp: 32'h00000000};
    vecs[3] = '{bytes_in: 32'h01020304, exp: 32'h04030201};

    do_reset(1'b1);
    run_table(1'b0, "table");
    chk("table cpu_empty in run", {31'd0, cpu_empty}, 32'd1);

    do_reset(1'b0);
    run_table(1'b1, "stall table");

    // Zero-length image
    do_reset(1'b0);
    stim.delete();
    stim.push_back(8'h99);
    push_le(32'd0);
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    model();
    send_stim();
    wait_boot("n0");
    tick(2);
    compare_load("n0");

    // Ack held off by a full tx FIFO
    do_reset(1'b0);
    full = 1'b1;
    build_random(1, 1'b1, 0);
    model();
    send_stim();
    wait_drain("full");
    cnt = 0;
    repeat (20) begin
      tick(1);
      if (uart_wr_en) cnt++;
    end
    chk("full ack held", cnt, 32'd0);
    chk("full no boot", {31'd0, boot_done}, 32'd0);
    full = 1'b0;
    wait_boot("full");
    tick(2);
    compare_load("full");

`ifdef LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      do_reset(1'b0);
      stim.delete();
      stim.push_back(8'h99);
      push_le(32'd1);
      push_le(32'h04030201);
      stim.push_back((k == 0) ? 8'h0A : 8'h0B);
      send_stim();
      wait_boot("csum");
      tick(2);
      chk("csum ntx", tx_q.size(), 32'd1);
      if (tx_q.size() != 0) chk("csum ack", {24'd0, tx_q[0]}, (k == 0) ? 32'hAA : 32'h55);
      chk("csum word", (wd_q.size() != 0) ? wd_q[0] : 32'hFFFFFFFF, 32'h04030201);
    end
`endif

    // Randomized frames with trailing CPU bytes
    for (int it = 0; it < 6; it++) begin
      logic [7:0] t0;
      logic [7:0] t1;
      do_reset(1'b0);
      build_random($urandom_range(0, 5), ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
      model();
      t0 = 8'($urandom_range(0, 255));
      t1 = 8'($urandom_range(0, 255));
      stim.push_back(t0);
      stim.push_back(t1);
      stall_en = (it % 2 == 1);
      send_stim();
      wait_boot("rand");
      stall_en = 1'b0;
      tick(2);
      compare_load("rand");
      chk("rand cpu_empty", {31'd0, cpu_empty}, 32'd0);
      chk("rand cpu_rx_data", {24'd0, cpu_rx_data}, {24'd0, t0});
      if (it == 5) begin
        cpu_rd_en = 1'b1;
        #1;
        chk("pass rd_en hi", {31'd0, uart_rd_en}, 32'd1);
        tick(1);
        cpu_rd_en = 1'b0;
        #1;
        chk("pass rd_en lo", {31'd0, uart_rd_en}, 32'd0);
        tick(1);
        chk("pass next byte", {24'd0, cpu_rx_data}, {24'd0, t1});
        cpu_wr_en = 1'b1;
        cpu_tx_data = 8'h3C;
        #1;
        chk("pass wr_en hi", {31'd0, uart_wr_en}, 32'd1);
        chk("pass tx_data", {24'd0, uart_tx_data}, 32'h3C);
        cpu_wr_en = 1'b0;
        #1;
        chk("pass wr_en lo", {31'd0, uart_wr_en}, 32'd0);
        full = 1'b1;
        #1;
        chk("pass cpu_full", {31'd0, cpu_full}, 32'd1);
        full = 1'b0;
        #1;
        chk("pass cpu_full lo", {31'd0, cpu_full}, 32'd0);
        chk("run sticky", {31'd0, boot_done}, 32'd1);
      end
    end

    // Reset partway through the first data word
    do_reset(1'b0);
    stim.delete();
    stim.push_back(8'h99);
    push_le(32'd1);
    stim.push_back(8'hAA);
    stim.push_back(8'hBB);
    send_stim();
    wait_drain("abort");
    chk("abort no write", wd_q.size(), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("abort addr", {18'd0, imem_addr}, 32'd0);
    chk("abort boot_done", {31'd0, boot_done}, 32'd0);
    clear_capture();
    build_random(2, 1'b1, 1);
    model();
    send_stim();
    wait_boot("after abort");
    tick(2);
    compare_load("after abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
